uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, SHALL set the maximum bytes sent per grant before forced release.
REQ-002 Parameter ACK_TIMEOUT, default 255, SHALL set the maximum cycles waited for tx_busy rise after tx_start.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester N offers a byte.
REQ-006 req0_data / req1_data  in  8  offered byte.
REQ-007 req0_last / req1_last  in  1  offered byte ends the requester's message.
REQ-008 req0_ready / req1_ready  out  1  byte accepted this cycle (valid & ready = transfer).
REQ-009 tx_start  out  1  one-cycle pulse that launches the downstream UART transmitter.
REQ-010 tx_data  out  8  byte to transmit, stable from tx_start until tx_busy falls.
REQ-011 tx_busy  in  1  downstream transmitter busy; high from launch to stop-bit end.
REQ-012 grant  out  2  one-hot owner of the transmitter, 00 when idle.
REQ-013 err_timeout  out  1  sticky flag: tx_busy never rose within ACK_TIMEOUT.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, START, WAIT_ACK and WAIT_DONE.
REQ-015 IDLE: if any valid, the block SHALL set grant round-robin (the requester not granted last wins a tie; first tie after reset goes to req0) and go to FETCH next cycle.
REQ-016 FETCH: ready SHALL equal valid of the granted requester only (combinational); on transfer, data/last captured, go to START; without valid, stay in FETCH holding grant.
REQ-017 START: tx_start SHALL be 1 for exactly one cycle with tx_data = captured byte; go to WAIT_ACK.
REQ-018 Latency: valid seen in IDLE at cycle t SHALL give ready at t+1 and tx_start at t+2.
REQ-019 WAIT_ACK: on tx_busy=1, go to WAIT_DONE; the wait counter SHALL start at 0 in START and compare with ACK_TIMEOUT.
REQ-020 When the counter reaches ACK_TIMEOUT, err_timeout SHALL set, the byte SHALL be dropped, and the grant SHALL be released (to IDLE).
REQ-021 WAIT_DONE: on tx_busy=0, if captured last=0 and burst count < MAX_BURST, go to FETCH with the same grant; otherwise release to IDLE and record the owner as last granted.
REQ-022 The burst counter SHALL clear on grant, increment per transfer, and be wide enough for MAX_BURST without wrap.
REQ-023 A forced release at MAX_BURST with last=0 SHALL let the other requester win if valid; the preempted requester SHALL resume later with no byte lost or duplicated.
REQ-024 Non-granted requesters SHALL see ready=0 at all times; both ready signals SHALL never be high together.
REQ-025 tx_busy already high in IDLE/FETCH SHALL be ignored; the ack SHALL be sampled only in WAIT_ACK.
REQ-026 Simultaneous valid on both in IDLE SHALL yield exactly one grant per REQ-015.

Reset
REQ-027 While n_reset=0: state IDLE, grant=00, tx_start=0, tx_data=00, ready=0, err_timeout=0, counters=0, last-granted=req1.
REQ-028 Reset mid-transfer SHALL discard the captured byte with no tx_start afterwards; the first cycle after release SHALL behave as IDLE.

Structure
REQ-029 FSM state encoding and the grant encodings SHALL live in the shared uart package alongside existing UART constants.
REQ-030 The round-robin choice SHALL be a sub-module rr_arb2 (inputs: two requests and last-granted; output: one-hot pick), purely combinational.

Verification
REQ-031 Single byte: req0 sends 0x41 last=1; tx_busy model rises 2 cycles after tx_start and is high for 320 cycles -> ready at t+1, tx_start at t+2 with tx_data=0x41, grant 01 then 00.
REQ-032 Contention: both valid at the same cycle after reset with last=1 -> req0 first, then req1; repeat -> the order alternates.
REQ-033 Message lock: req0 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) while req1 is valid -> req1 gets no ready until 0x12 completes.
REQ-034 Burst limit: MAX_BURST=4, req0 streams 6 bytes last=0, req1 valid -> 4 req0 bytes, then req1, then req0 byte 5.
REQ-035 Timeout: tx_busy held 0 -> err_timeout set ACK_TIMEOUT cycles after tx_start, grant 00, next request still served.
REQ-036 Reset in WAIT_DONE: assert n_reset low -> all outputs at reset values immediately; no spurious tx_start after release.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: byte width and beat payload, plus the arbiter's
// FSM state encoding and one-hot grant encodings.
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned GRANT_W     = 2;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;
    typedef logic [GRANT_W-1:0]     grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_REQ0 = 2'b01;
    localparam grant_t GRANT_REQ1 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

    // One byte offered by a requester, with its end-of-message marker.
    typedef struct packed {
        uart_byte_t data;
        logic       last;
    } req_beat_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and transmitter-side signals of the UART TX arbiter.
interface uart_tx_arbiter_if;
    import uart_tx_arbiter_pkg::*;

    logic       req0_valid;
    uart_byte_t req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    uart_byte_t req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_start;
    uart_byte_t tx_data;
    logic       tx_busy;
    grant_t     grant;
    logic       err_timeout;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_start, tx_data, grant, err_timeout
    );

    // Requester / transmitter side.
    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_start, tx_data, grant, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2
    import uart_tx_arbiter_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  grant_t last,
    output grant_t pick
);

    always_comb begin
        pick = GRANT_NONE;
        if (req0 && req1) begin
            pick = (last == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
        end else if (req0) begin
            pick = GRANT_REQ0;
        end else if (req1) begin
            pick = GRANT_REQ1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter for one UART transmitter: a grant is held for a whole
// message (capped at MAX_BURST bytes) and each launch must be acknowledged by tx_busy.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             n_reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam int unsigned ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned ACK_CW  = ACK_W + 1;

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [ACK_CW-1:0]  ACK_LIMIT   = ACK_CW'(ACK_TIMEOUT);

    arb_state_t         state_q, state_d;
    grant_t             grant_q, grant_d;
    grant_t             last_grant_q, last_grant_d;
    grant_t             pick;
    logic               tx_start_q, tx_start_d;
    uart_byte_t         tx_data_q, tx_data_d;
    logic               msg_last_q, msg_last_d;
    logic               err_q, err_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [ACK_CW-1:0]  ack_next;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               fetching;
    logic               xfer;
    req_beat_t          sel_beat;

    rr_arb2 u_rr_arb2 (
        .req0 (bus.req0_valid),
        .req1 (bus.req1_valid),
        .last (last_grant_q),
        .pick (pick)
    );

    // Only the owner sees ready, and only while the arbiter is fetching.
    assign fetching       = (state_q == ST_FETCH);
    assign bus.req0_ready = fetching && (grant_q == GRANT_REQ0) && bus.req0_valid;
    assign bus.req1_ready = fetching && (grant_q == GRANT_REQ1) && bus.req1_valid;
    assign xfer           = bus.req0_ready || bus.req1_ready;
    assign sel_beat       = (grant_q == GRANT_REQ1) ? {bus.req1_data, bus.req1_last}
                                                    : {bus.req0_data, bus.req0_last};

    // Cycles elapsed since tx_start, one ahead of the stored count.
    assign ack_next = ACK_CW'(ack_cnt_q) + ACK_CW'(1);

    assign bus.grant       = grant_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.err_timeout = err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_NONE;
            last_grant_q <= GRANT_REQ1;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            msg_last_q   <= 1'b0;
            err_q        <= 1'b0;
            ack_cnt_q    <= '0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            msg_last_q   <= msg_last_d;
            err_q        <= err_d;
            ack_cnt_q    <= ack_cnt_d;
            burst_q      <= burst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        msg_last_d   = msg_last_q;
        err_d        = err_q;
        ack_cnt_d    = ack_cnt_q;
        burst_d      = burst_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick != GRANT_NONE) begin
                    grant_d = pick;
                    burst_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // tx_start is registered so it lands in the START cycle.
                if (xfer) begin
                    tx_data_d  = sel_beat.data;
                    msg_last_d = sel_beat.last;
                    tx_start_d = 1'b1;
                    ack_cnt_d  = '0;
                    burst_d    = burst_q + BURST_W'(1);
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                ack_cnt_d = ack_next[ACK_W-1:0];
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_next >= ACK_LIMIT) begin
                    // No acknowledge: drop the byte and free the transmitter.
                    err_d   = 1'b1;
                    grant_d = GRANT_NONE;
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_next[ACK_W-1:0];
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (!msg_last_q && (burst_q < BURST_LIMIT)) begin
                        state_d = ST_FETCH;
                    end else begin
                        last_grant_d = grant_q;
                        grant_d      = GRANT_NONE;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
